// File: rtl/count_min_hour_pkg.sv
// Shared clock-datapath definitions: FSM encodings, field widths, wrap defaults
// and the 24 h -> 12 h display helper used by the time stages.
package count_min_hour_pkg;

    localparam int MIN_W        = 6;
    localparam int HOUR_W       = 5;
    localparam int MIN_MAX_DEF  = 59;
    localparam int HOUR_MAX_DEF = 23;

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_SET_HOUR = 2'b01;
    localparam logic [1:0] ST_SET_MIN  = 2'b10;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic              pm;
    } disp_t;

    // Midnight reads as 12 AM and noon as 12 PM.
    function automatic disp_t to_12h(input logic [HOUR_W-1:0] h);
        disp_t d;
        if (h == 5'd0) begin
            d.hour = 5'd12;
            d.pm   = 1'b0;
        end else if (h < 5'd12) begin
            d.hour = h;
            d.pm   = 1'b0;
        end else if (h == 5'd12) begin
            d.hour = 5'd12;
            d.pm   = 1'b1;
        end else begin
            d.hour = h - 5'd12;
            d.pm   = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a clean level button; history resets to 1 so a
// button already held when reset releases never produces an edge.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 1'b1;
        end else begin
            hist <= btn;
        end
    end

    assign rise = btn & ~hist;

endmodule

// File: rtl/count_min_hour.sv
// Minute/hour stage of the clock datapath: wrap counters driven by the minute
// carry, a two-button time-set FSM, day carry and 12 h display conversion.
module count_min_hour
    import count_min_hour_pkg::*;
#(
    parameter int MIN_MAX  = MIN_MAX_DEF,
    parameter int HOUR_MAX = HOUR_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_min,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              mode_12h,
    output logic [MIN_W-1:0]  cnt_min,
    output logic [HOUR_W-1:0] cnt_hour,
    output logic [HOUR_W-1:0] disp_hour,
    output logic              pm,
    output logic [1:0]        set_state,
    output logic              pulse_day,
    output logic              clr_sec
);

    localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX);

    logic       mode_edge;
    logic       up_edge;
    logic [1:0] state;
    disp_t      conv;

    btn_edge u_mode_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_mode),
        .rise (mode_edge)
    );

    btn_edge u_up_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_up),
        .rise (up_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            cnt_min   <= '0;
            cnt_hour  <= '0;
            pulse_day <= 1'b0;
            clr_sec   <= 1'b0;
        end else begin
            pulse_day <= 1'b0;
            clr_sec   <= 1'b0;
            case (state)
                ST_RUN: begin
                    // Minute carry is honoured even when the mode press leaves RUN this cycle.
                    if (pulse_min) begin
                        if (cnt_min == MIN_LAST) begin
                            cnt_min <= '0;
                            if (cnt_hour == HOUR_LAST) begin
                                cnt_hour  <= '0;
                                pulse_day <= 1'b1;
                            end else begin
                                cnt_hour <= cnt_hour + 5'd1;
                            end
                        end else begin
                            cnt_min <= cnt_min + 6'd1;
                        end
                    end
                    if (mode_edge) state <= ST_SET_HOUR;
                end
                ST_SET_HOUR: begin
                    if (up_edge) begin
                        cnt_hour <= (cnt_hour == HOUR_LAST) ? '0 : cnt_hour + 5'd1;
                    end
                    if (mode_edge) state <= ST_SET_MIN;
                end
                ST_SET_MIN: begin
                    if (up_edge) begin
                        cnt_min <= (cnt_min == MIN_LAST) ? '0 : cnt_min + 6'd1;
                    end
                    // Leaving set mode restarts the seconds from zero.
                    if (mode_edge) begin
                        state   <= ST_RUN;
                        clr_sec <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign set_state = state;

    always_comb begin
        conv = to_12h(cnt_hour);
        if (mode_12h) begin
            disp_hour = conv.hour;
            pm        = conv.pm;
        end else begin
            disp_hour = cnt_hour;
            pm        = 1'b0;
        end
    end

endmodule

// File: tb/tb_count_min_hour.sv
// Scoreboard bench for count_min_hour: directed scenarios plus random buttons
// and minute carries, checked against a time-of-day reference model.
module tb_count_min_hour;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_min = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       mode_12h = 1'b0;
    logic [5:0] cnt_min;
    logic [4:0] cnt_hour;
    logic [4:0] disp_hour;
    logic       pm;
    logic [1:0] set_state;
    logic       pulse_day;
    logic       clr_sec;

    count_min_hour dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_min (pulse_min),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .mode_12h  (mode_12h),
        .cnt_min   (cnt_min),
        .cnt_hour  (cnt_hour),
        .disp_hour (disp_hour),
        .pm        (pm),
        .set_state (set_state),
        .pulse_day (pulse_day),
        .clr_sec   (clr_sec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mn;
        int hr;
        int disp;
        int pmv;
        int st;
        int day;
        int clr;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference model state: time kept as minute-of-day.
    int tod = 0;
    int mst = 0;
    int bm_prev = 1;
    int bu_prev = 1;
    int mday = 0;
    int mclr = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_step(input int r, input int pmin, input int bm, input int bu);
        int me, ue, h, m;
        if (r != 0) begin
            tod = 0; mst = 0; mday = 0; mclr = 0; bm_prev = 1; bu_prev = 1;
        end else begin
            me = (bm != 0 && bm_prev == 0) ? 1 : 0;
            ue = (bu != 0 && bu_prev == 0) ? 1 : 0;
            mday = 0;
            mclr = 0;
            h = tod / 60;
            m = tod % 60;
            if (mst == 0) begin
                if (pmin != 0) begin
                    tod = (tod + 1) % 1440;
                    if (tod == 0) mday = 1;
                end
                if (me != 0) mst = 1;
            end else if (mst == 1) begin
                if (ue != 0) tod = ((h + 1) % 24) * 60 + m;
                if (me != 0) mst = 2;
            end else begin
                if (ue != 0) tod = h * 60 + (m + 1) % 60;
                if (me != 0) begin
                    mst = 0;
                    mclr = 1;
                end
            end
            bm_prev = bm;
            bu_prev = bu;
        end
    endtask

    // Drive one cycle's inputs, queue the expectation, return at the next negedge.
    task automatic cyc(input int r, input int pmin, input int bm, input int bu);
        exp_t e;
        int h;
        rst = (r != 0);
        pulse_min = (pmin != 0);
        btn_mode = (bm != 0);
        btn_up = (bu != 0);
        model_step(r, pmin, bm, bu);
        h = tod / 60;
        e.mn = tod % 60;
        e.hr = h;
        if (mode_12h) begin
            e.disp = (h % 12 == 0) ? 12 : h % 12;
            e.pmv = (h >= 12) ? 1 : 0;
        end else begin
            e.disp = h;
            e.pmv = 0;
        end
        e.st = mst;
        e.day = mday;
        e.clr = mclr;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic press_mode();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 0);
        end
    endtask

    // Monitor: every rising edge produces a new output word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("cnt_min", int'(cnt_min), e.mn);
                chk("cnt_hour", int'(cnt_hour), e.hr);
                chk("disp_hour", int'(disp_hour), e.disp);
                chk("pm", int'(pm), e.pmv);
                chk("set_state", int'(set_state), e.st);
                chk("pulse_day", int'(pulse_day), e.day);
                chk("clr_sec", int'(clr_sec), e.clr);
            end
        end
    end

    initial begin
        // Reset with mode held; held button must not register after release of reset.
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        chk("reset_min", int'(cnt_min), 0);
        chk("reset_hour", int'(cnt_hour), 0);
        chk("reset_state", int'(set_state), 0);
        chk("reset_clr", int'(clr_sec), 0);
        cyc(0, 0, 1, 0);
        chk("held_no_edge", int'(set_state), 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("press_to_set_hour", int'(set_state), 1);
        cyc(0, 0, 0, 0);

        // Held up button counts once.
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("held_up_once", int'(cnt_hour), 1);

        // Preload 12:59 and return to RUN.
        press_up(11);
        press_mode();
        press_up(59);
        cyc(0, 0, 1, 0);
        chk("exit_state_run", int'(set_state), 0);
        chk("clr_sec_pulse", int'(clr_sec), 1);
        cyc(0, 0, 0, 0);
        chk("clr_sec_once", int'(clr_sec), 0);

        mode_12h = 1'b1;
        cyc(0, 1, 0, 0);
        chk("1259_hour", int'(cnt_hour), 13);
        chk("1259_min", int'(cnt_min), 0);
        chk("1259_disp", int'(disp_hour), 1);
        chk("1259_pm", int'(pm), 1);
        chk("1259_day", int'(pulse_day), 0);

        // Preload 23:59; pulse_min in SET_MIN is dropped.
        press_mode();
        press_up(10);
        press_mode();
        press_up(59);
        cyc(0, 1, 0, 0);
        chk("set_min_ignores_pulse", int'(cnt_min), 59);
        press_mode();
        cyc(0, 1, 0, 0);
        chk("midnight_hour", int'(cnt_hour), 0);
        chk("midnight_min", int'(cnt_min), 0);
        chk("midnight_day", int'(pulse_day), 1);
        chk("midnight_disp", int'(disp_hour), 12);
        chk("midnight_pm", int'(pm), 0);
        cyc(0, 0, 0, 0);
        chk("day_once", int'(pulse_day), 0);

        // Hour wrap in SET_HOUR: 5 plus 24 presses returns to 5.
        mode_12h = 1'b0;
        press_mode();
        press_up(5);
        press_up(24);
        chk("hour_full_wrap", int'(cnt_hour), 5);
        press_mode();
        press_up(59);
        press_up(1);
        chk("min_wrap_min", int'(cnt_min), 0);
        chk("min_wrap_hour", int'(cnt_hour), 5);
        press_mode();

        // Same-cycle pulse_min and mode press at 10:59.
        press_mode();
        press_up(5);
        press_mode();
        press_up(59);
        press_mode();
        cyc(0, 1, 1, 0);
        chk("sim_hour", int'(cnt_hour), 11);
        chk("sim_min", int'(cnt_min), 0);
        chk("sim_state", int'(set_state), 1);
        cyc(0, 0, 0, 0);
        press_mode();
        cyc(1, 0, 0, 0);
        chk("rst_mid_state", int'(set_state), 0);
        chk("rst_mid_hour", int'(cnt_hour), 0);
        chk("rst_mid_clr", int'(clr_sec), 0);

        // Random traffic.
        begin
            int bm, bu, r;
            bm = 0;
            bu = 0;
            for (int i = 0; i < 4000; i++) begin
                r = ($urandom_range(0, 299) == 0) ? 1 : 0;
                if ($urandom_range(0, 5) == 0) bm = 1 - bm;
                if ($urandom_range(0, 2) == 0) bu = 1 - bu;
                if ($urandom_range(0, 39) == 0) mode_12h = ~mode_12h;
                cyc(r, ($urandom_range(0, 1) == 0) ? 1 : 0, bm, bu);
            end
        end

        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_min_hour.md
Name: count_min_hour

Overview:
- Downstream stage of the seconds counter in the Lab 3 clock datapath.
- Consumes the one-cycle minute carry and keeps minutes (0-59) and hours (0-23).
- Provides a two-button time-set FSM, 12 h display conversion and a one-cycle day carry for the date stage.
- Also issues a one-cycle seconds-clear request when a time-set session ends.

Parameters:
- MIN_MAX, 59, last minute value before wrap.
- HOUR_MAX, 23, last hour value before wrap.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pulse_min  in  1  one-cycle minute carry from the seconds stage.
- btn_mode  in  1  mode button; already synchronised and debounced; level, active-high.
- btn_up  in  1  increment button; already synchronised and debounced; level, active-high.
- mode_12h  in  1  1 selects 12 h format on disp_hour and pm.
- cnt_min  out  6  current minute, 0..MIN_MAX.
- cnt_hour  out  5  current hour, 24 h format, 0..HOUR_MAX.
- disp_hour  out  5  hour for the display: 24 h value, or 1..12 when mode_12h=1.
- pm  out  1  1 when mode_12h=1 and cnt_hour>=12; otherwise 0.
- set_state  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; drives display blinking.
- pulse_day  out  1  one-cycle pulse on the 23:59 -> 00:00 rollover.
- clr_sec  out  1  one-cycle request to clear the seconds counter.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. There is no asynchronous path.
- Reset values: cnt_min=0, cnt_hour=0, state=RUN, pulse_day=0, clr_sec=0.
- Reset also sets both edge-detector history registers to 1. A button held through reset therefore produces no edge.
- Edge detect: mode_edge = btn_mode & ~btn_mode_q; up_edge = btn_up & ~btn_up_q. Holding a button gives exactly one action, never one per clock.
- FSM, on mode_edge:
  - RUN -> SET_HOUR.
  - SET_HOUR -> SET_MIN.
  - SET_MIN -> RUN.
  - clr_sec=1 for the single cycle following the SET_MIN -> RUN transition.
- RUN:
  - On pulse_min, cnt_min increments.
  - At MIN_MAX, cnt_min wraps to 0 and cnt_hour increments.
  - At HOUR_MAX, cnt_hour wraps to 0 and pulse_day=1 in the same registered cycle in which the counters read 00:00.
  - Latency: counters update on the first clock edge after pulse_min is sampled high.
- SET_HOUR: up_edge increments cnt_hour; HOUR_MAX wraps to 0. No carry, no pulse_day.
- SET_MIN: up_edge increments cnt_min; MIN_MAX wraps to 0. No carry into hours, no pulse_day.
- In SET states, pulse_min is ignored (dropped, not queued). up_edge is ignored in RUN.
- pulse_day and clr_sec are registered and default to 0 every cycle unless set as above.
- Simultaneous events:
  - pulse_min with mode_edge in RUN: the minute increment is applied and the state moves to SET_HOUR in the same cycle.
  - up_edge with mode_edge in a SET state: the increment applies to the field of the current (old) state, then the state advances.
- Reset has priority over all events. Reset mid-set returns to RUN at 00:00 with no clr_sec pulse.
- 12 h conversion (combinational from cnt_hour, zero added latency):
  - 0 -> 12, pm=0.
  - 1..11 -> same value, pm=0.
  - 12 -> 12, pm=1.
  - 13..23 -> cnt_hour-12, pm=1.
  - With mode_12h=0: disp_hour=cnt_hour and pm=0.
- Width rules: all comparisons against the parameters are unsigned, and counters never exceed their MAX.

Decomposition:
- Shared clock package holds:
  - state encodings ST_RUN=2'b00, ST_SET_HOUR=2'b01, ST_SET_MIN=2'b10;
  - MIN_MAX/HOUR_MAX defaults;
  - width constants MIN_W=6, HOUR_W=5.
  - The seconds, minute/hour and date stages all import it.
- One natural sub-module: btn_edge (one-register rising-edge detector with reset-to-1 history), instantiated twice.
- The wrap counters stay inline.

Test Plan:
- Reset with btn_mode held high, then release and press again -> no edge on the first cycle; the second press gives set_state 00->01.
- Preload 12:59 via set mode, return to RUN, one pulse_min -> next cycle 13:00, pulse_day=0; with mode_12h=1, disp_hour=1 and pm=1.
- 23:59 in RUN, pulse_min -> next cycle 00:00, pulse_day=1 for exactly one cycle; disp_hour=12 and pm=0 in 12 h mode.
- Enter SET_HOUR, hold btn_up for 10 cycles -> hour increments by 1 only; 24 separate presses from 5 -> returns to 5 with no pulse_day.
- SET_MIN at 59, up press -> 00 with hour unchanged; pulse_min during SET_MIN -> no change. Mode press to RUN -> set_state=00, then clr_sec=1 for exactly one cycle.
- Same-cycle pulse_min and mode_edge at 10:59 in RUN -> 11:00 and set_state=01. Assert rst in SET_MIN -> 00:00, RUN, clr_sec=0.
